// File: rtl/mux_nx1_stream.sv
// ---------------------------------------------------------------------------
// mux_nx1_stream
//   N-to-1 stream multiplexer with valid/ready handshaking and a single
//   registered output stage. Sits between several producer channels and one
//   shared consumer.
//   mode=0 routes the channel chosen by sel. mode=1 grants channels in
//   round-robin order, starting the search at the channel after the last one
//   served.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    channel k word at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   out_data   registered output word
//   out_ch     registered index of the channel that produced out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  downstream accepts the word
// ---------------------------------------------------------------------------
module mux_nx1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS-1);

  logic [SEL_W-1:0]    r_ptr;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_ch;
  logic                r_valid;

  logic                w_load_en;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_gnt_vld;
  logic [SEL_W-1:0]    w_gnt;
  logic [CHANNELS-1:0] w_gnt_oh;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_data;
  logic [SEL_W-1:0]    w_ptr_next;

  // Single output stage: it can take a new word whenever it is empty or its
  // current word leaves in this same cycle.
  assign w_load_en = !r_valid || out_ready;

  // Round-robin search: visit ptr, ptr+1, ... modulo CHANNELS and take the
  // first requester. The sum is one bit wider so the modulo reduction is a
  // single conditional subtract, which also covers non-power-of-2 counts.
  always_comb begin : rr_scan
    logic [SEL_W:0] cand;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    cand       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (cand >= CH_CNT) begin
        cand = cand - CH_CNT;
      end
      if (!w_rr_found && in_valid[cand[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand[SEL_W-1:0];
      end
    end
  end

  // Fixed mode grants sel regardless of its valid, so in_ready does not
  // depend on in_valid there; an out-of-range sel grants nothing.
  always_comb begin
    if (mode) begin
      w_gnt_vld = w_rr_found;
      w_gnt     = w_rr_idx;
    end else begin
      w_gnt_vld = ({1'b0, sel} < CH_CNT);
      w_gnt     = sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign w_gnt_oh[gi] = w_gnt_vld && (w_gnt == SEL_W'(gi));
      // rst_n gating keeps every ready low while the block is held in reset.
      assign in_ready[gi] = w_gnt_oh[gi] && w_load_en && rst_n;
    end
  endgenerate

  assign w_xfer = (|(w_gnt_oh & in_valid)) && w_load_en;

  // AND-OR selection: non-granted channels are masked to zero before the OR,
  // so unknown data on idle channels cannot reach the output register.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_data = w_data | ({WIDTH{w_gnt_oh[k]}} & in_data[k*WIDTH +: WIDTH]);
    end
  end

  assign w_ptr_next = (w_gnt == CH_LAST) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        // Also covers drain-and-refill in one cycle: the new word simply
        // overwrites the departing one, no bubble.
        r_data  <= w_data;
        r_ch    <= w_gnt;
        r_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_ptr_next;
        end
      end else if (out_ready) begin
        // Drain: data and channel keep their last values.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nx1_stream.sv
module tb_mux_nx1_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-channel instance
  logic        mode8;
  logic [2:0]  sel8;
  logic [63:0] din8;
  logic [7:0]  iv8;
  logic [7:0]  ir8;
  logic [7:0]  od8;
  logic [2:0]  oc8;
  logic        ov8;
  logic        ordy8;

  // 5-channel instance (non-power-of-2 wrap)
  logic        mode5;
  logic [2:0]  sel5;
  logic [39:0] din5;
  logic [4:0]  iv5;
  logic [4:0]  ir5;
  logic [7:0]  od5;
  logic [2:0]  oc5;
  logic        ov5;
  logic        ordy5;

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
    .in_data(din8), .in_valid(iv8), .in_ready(ir8),
    .out_data(od8), .out_ch(oc8), .out_valid(ov8), .out_ready(ordy8)
  );

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(din5), .in_valid(iv5), .in_ready(ir5),
    .out_data(od5), .out_ch(oc5), .out_valid(ov5), .out_ready(ordy5)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp8;
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  // Compare an outgoing word against the oldest accepted word.
  task automatic sb_pop;
    logic [31:0] exp;
    if (ov8 && ordy8) begin
      exp = (sb_q.size() != 0) ? {21'd0, sb_q.pop_front()} : 32'hDEAD_BEEF;
      chk("sb_word", {21'd0, oc8, od8}, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_ch;
    logic [2:0] alt_seq [4];
    alt_seq = '{3'd2, 3'd7, 3'd2, 3'd7};

    rst_n = 1'b0;
    mode8 = 1'b0; sel8 = 3'd0; iv8 = 8'hFF; ordy8 = 1'b1; set_ramp8();
    mode5 = 1'b0; sel5 = 3'd0; iv5 = 5'h00; ordy5 = 1'b1;
    for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'(8'h50 + k);

    // Reset state
    #12;
    chk("rst_ov", ov8, 0);
    chk("rst_od", od8, 0);
    chk("rst_oc", oc8, 0);
    chk("rst_ir8", ir8, 0);
    chk("rst_ir5", ir5, 0);
    step();
    rst_n = 1'b1;

    // T2 fixed sweep
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      #1;
      chk("t2_ready", ir8, 32'(1 << s));
      step();
      chk("t2_data", od8, 32'(8'h10 + s));
      chk("t2_ch", oc8, 32'(s));
      chk("t2_valid", ov8, 1);
      $display("T2 sel=%0d out_ch=%0d out_data=%h", s, oc8, od8);
    end

    // T3 backpressure
    sel8 = 3'd3;
    step();
    chk("t3_first", od8, 8'h13);
    ordy8 = 1'b0;
    din8[24 +: 8] = 8'h33;
    #1;
    chk("t3_stall_ready", ir8, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_hold_data", od8, 8'h13);
      chk("t3_hold_valid", ov8, 1);
      chk("t3_hold_ready", ir8, 0);
      $display("T3 stall cycle %0d out_data=%h", c, od8);
    end
    ordy8 = 1'b1;
    #1;
    chk("t3_release_ready", ir8, 8'h08);
    step();
    chk("t3_next_data", od8, 8'h33);
    chk("t3_next_ch", oc8, 3);
    chk("t3_next_valid", ov8, 1);
    $display("T3 release out_ch=%0d out_data=%h", oc8, od8);

    // Drain with no new transfer; ready in fixed mode ignores valid
    iv8 = 8'h00;
    #1;
    chk("drain_ready", ir8, 8'h08);
    step();
    chk("drain_valid", ov8, 0);
    chk("drain_hold_data", od8, 8'h33);
    chk("drain_hold_ch", oc8, 3);
    $display("DRAIN out_valid=%0d out_data=%h", ov8, od8);

    // Unknown data on non-granted channels must not reach the output
    iv8 = 8'hFF;
    din8 = 'x;
    din8[8 +: 8] = 8'h11;
    sel8 = 3'd1;
    step();
    chk("nox_data", od8, 8'h11);
    chk("nox_ch", oc8, 1);
    $display("NOX out_ch=%0d out_data=%h", oc8, od8);
    set_ramp8();

    // T1 asynchronous reset mid-stream with a held word
    ordy8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_ov", ov8, 0);
    chk("t1_od", od8, 0);
    chk("t1_oc", oc8, 0);
    chk("t1_ir", ir8, 0);
    $display("T1 async reset out_valid=%0d", ov8);
    step();
    rst_n = 1'b1;

    // T4 round-robin, all channels valid
    mode8 = 1'b1; iv8 = 8'hFF; ordy8 = 1'b1;
    for (int n = 0; n < 9; n++) begin
      exp_ch = 3'(n % 8);
      #1;
      chk("t4_ready", ir8, 32'(1 << exp_ch));
      step();
      chk("t4_ch", oc8, exp_ch);
      chk("t4_data", od8, 32'(8'h10 + exp_ch));
      $display("T4 out_ch=%0d out_data=%h", oc8, od8);
    end
    iv8 = 8'b1000_0100;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t4_alt_ch", oc8, alt_seq[n]);
      $display("T4 alt out_ch=%0d", oc8);
    end

    // T5 non-power-of-2 wrap on the 5-channel instance
    mode5 = 1'b1; iv5 = 5'h1F;
    for (int n = 0; n < 6; n++) begin
      exp_ch = 3'(n % 5);
      step();
      chk("t5_ch", oc5, exp_ch);
      chk("t5_data", od5, 32'(8'h50 + exp_ch));
      $display("T5 out_ch=%0d out_data=%h", oc5, od5);
    end
    mode5 = 1'b0; sel5 = 3'd6;
    #1;
    chk("t5_oor_ready", ir5, 0);
    step();
    chk("t5_oor_valid", ov5, 0);
    chk("t5_oor_ch", oc5, 0);
    $display("T5 sel=6 out_valid=%0d", ov5);
    sel5 = 3'd4;
    #1;
    chk("t5_sel4_ready", ir5, 5'h10);
    step();
    chk("t5_sel4_ch", oc5, 4);
    chk("t5_sel4_data", od5, 8'h54);
    iv5 = 5'h00;

    // T6 random traffic against a scoreboard
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      mode8 = 1'($urandom_range(0, 1));
      sel8  = 3'($urandom_range(0, 7));
      iv8   = 8'($urandom);
      ordy8 = ($urandom_range(0, 3) != 0);
      din8  = {$urandom, $urandom};
      #1;
      chk("t6_onehot0", $onehot0(ir8), 1);
      if (!mode8) chk("t6_fixed_ready", ir8, (!ov8 || ordy8) ? 32'(1 << sel8) : 32'd0);
      else if (iv8 == 8'h00) chk("t6_rr_idle", ir8, 0);
      sb_pop();
      for (int k = 0; k < 8; k++) begin
        if (ir8[k] && iv8[k]) sb_q.push_back({3'(k), din8[k*8 +: 8]});
      end
      step();
    end
    iv8 = 8'h00; ordy8 = 1'b1; mode8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      sb_pop();
      step();
    end
    chk("t6_leftover", sb_q.size(), 0);
    chk("t6_final_valid", ov8, 0);
    $display("T6 random done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
